// File: rtl/mc_controlunit.sv
// Multicycle ARM-subset control unit: FSM sequencing, DP decode, condition/flag tracking.
// Latency: one FSM state per clk; an instruction takes 3-5 states plus memory stalls.
// Backpressure: FETCH, MEMRD and MEMWR hold while mem_ready=0; strobes follow the state.
module mc_controlunit #(
  parameter int ALUCTL_W = 3,
  parameter bit EXT_OPS  = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         Instr,
  input  logic [3:0]          Flags,
  input  logic                mem_ready,
  output logic                PCWrite,
  output logic                IRWrite,
  output logic                MemWrite,
  output logic                RegWrite,
  output logic                AdrSrc,
  output logic                ALUSrcA,
  output logic [1:0]          ResultSrc,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ImmSrc,
  output logic [1:0]          RegSrc,
  output logic [ALUCTL_W-1:0] ALUControl,
  output logic [3:0]          state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
    S_MEMWB  = 4'd4, S_MEMWR  = 4'd5, S_EXECR  = 4'd6, S_EXECI = 4'd7,
    S_ALUWB  = 4'd8, S_BRANCH = 4'd9
  } state_t;

  state_t      cur, nxt;
  logic [3:0]  nzcv;
  logic        cond_q, cond_ex;
  logic [1:0]  op;
  logic        s_bit;
  logic [2:0]  dp_alu, alu_code;
  logic        dp_nowr, dp_fnz, dp_fcv;
  logic        regw, memw, branch, fetch_adv;
  logic        unused_bits;

  assign op          = Instr[27:26];
  assign s_bit       = Instr[20];
  assign state       = cur;
  assign unused_bits = ^{Instr[19:16], Instr[11:0]};

  // Data-processing decode: ALU op, compare-class (no register write), flag write enables.
  always_comb begin
    dp_alu  = 3'd0;
    dp_nowr = 1'b0;
    dp_fnz  = 1'b0;
    dp_fcv  = 1'b0;
    casez ({Instr[24:21], s_bit})
      5'b0100?: begin dp_alu = 3'd0; dp_fnz = s_bit; dp_fcv = s_bit; end
      5'b0010?: begin dp_alu = 3'd1; dp_fnz = s_bit; dp_fcv = s_bit; end
      5'b0000?: begin dp_alu = 3'd2; dp_fnz = s_bit; end
      5'b1100?: begin dp_alu = 3'd3; dp_fnz = s_bit; end
      5'b0001?: if (EXT_OPS) begin dp_alu = 3'd4; dp_fnz = s_bit; end
      5'b10101: begin dp_alu = 3'd1; dp_nowr = 1'b1; dp_fnz = 1'b1; dp_fcv = 1'b1; end
      5'b10001: if (EXT_OPS) begin dp_alu = 3'd2; dp_nowr = 1'b1; dp_fnz = 1'b1; end
      5'b10111: if (EXT_OPS) begin dp_alu = 3'd0; dp_nowr = 1'b1; dp_fnz = 1'b1; dp_fcv = 1'b1; end
      default: ;
    endcase
  end

  // ARM condition evaluation against the architectural NZCV register.
  always_comb begin
    cond_ex = 1'b1;
    case (Instr[31:28])
      4'h0: cond_ex = nzcv[2];
      4'h1: cond_ex = ~nzcv[2];
      4'h2: cond_ex = nzcv[1];
      4'h3: cond_ex = ~nzcv[1];
      4'h4: cond_ex = nzcv[3];
      4'h5: cond_ex = ~nzcv[3];
      4'h6: cond_ex = nzcv[0];
      4'h7: cond_ex = ~nzcv[0];
      4'h8: cond_ex = nzcv[1] & ~nzcv[2];
      4'h9: cond_ex = ~nzcv[1] | nzcv[2];
      4'hA: cond_ex = (nzcv[3] == nzcv[0]);
      4'hB: cond_ex = (nzcv[3] != nzcv[0]);
      4'hC: cond_ex = ~nzcv[2] & (nzcv[3] == nzcv[0]);
      4'hD: cond_ex = nzcv[2] | (nzcv[3] != nzcv[0]);
      default: cond_ex = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) cur <= S_FETCH;
    else       cur <= nxt;
  end

  // Condition latch at DECODE exit and NZCV update at EXEC exit (only when the condition held).
  always_ff @(posedge clk) begin
    if (reset) begin
      nzcv   <= 4'b0000;
      cond_q <= 1'b1;
    end else begin
      if (cur == S_DECODE) cond_q <= cond_ex;
      if ((cur == S_EXECR || cur == S_EXECI) && cond_q) begin
        if (dp_fnz) nzcv[3:2] <= Flags[3:2];
        if (dp_fcv) nzcv[1:0] <= Flags[1:0];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    nxt = S_FETCH;
    case (cur)
      S_FETCH:  nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: case (op)
                  2'b01:   nxt = S_MEMADR;
                  2'b00:   nxt = Instr[25] ? S_EXECI : S_EXECR;
                  2'b10:   nxt = S_BRANCH;
                  default: nxt = S_FETCH;
                endcase
      S_MEMADR: nxt = Instr[20] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  nxt = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  nxt = mem_ready ? S_FETCH : S_MEMWR;
      S_EXECR:  nxt = S_ALUWB;
      S_EXECI:  nxt = S_ALUWB;
      default:  nxt = S_FETCH;
    endcase
  end

  // Output decode from state and instruction; write strobes gated by cond_q and reset.
  always_comb begin
    regw      = 1'b0;
    memw      = 1'b0;
    branch    = 1'b0;
    fetch_adv = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    alu_code  = 3'd0;
    case (cur)
      S_FETCH:  begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10; fetch_adv = mem_ready; end
      S_DECODE: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10; end
      S_MEMADR: ALUSrcB = 2'b01;
      S_MEMRD:  AdrSrc = 1'b1;
      S_MEMWB:  begin ResultSrc = 2'b01; regw = 1'b1; end
      S_MEMWR:  begin AdrSrc = 1'b1; memw = 1'b1; end
      S_EXECR:  alu_code = dp_alu;
      S_EXECI:  begin ALUSrcB = 2'b01; alu_code = dp_alu; end
      S_ALUWB:  regw = ~dp_nowr;
      S_BRANCH: begin ALUSrcB = 2'b01; ResultSrc = 2'b10; branch = 1'b1; end
      default: ;
    endcase
    ALUControl = ALUCTL_W'(alu_code);
    ImmSrc     = op;
    RegSrc     = {(op == 2'b01) & ~Instr[20], (op == 2'b10)};
    IRWrite    = ~reset & fetch_adv;
    RegWrite   = ~reset & regw & cond_q;
    MemWrite   = ~reset & memw & cond_q;
    PCWrite    = ~reset & (fetch_adv | (cond_q & (branch | (regw & (Instr[15:12] == 4'hF)))));
  end

endmodule

// File: tb/tb_mc_controlunit.sv
// Bench for mc_controlunit: two instances (extended ops on/off) share stimulus.
// Each instruction is expanded by a behavioural model into per-cycle expectations.
// Memory stalls and flags are randomized; reset is exercised mid-instruction.
module tb_mc_controlunit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr;
  logic [3:0]  Flags;
  logic        mem_ready;

  logic       PCWrite1, IRWrite1, MemWrite1, RegWrite1, AdrSrc1, ALUSrcA1;
  logic [1:0] ResultSrc1, ALUSrcB1, ImmSrc1, RegSrc1;
  logic [2:0] ALUControl1;
  logic [3:0] state1;
  logic       PCWrite0, IRWrite0, MemWrite0, RegWrite0, AdrSrc0, ALUSrcA0;
  logic [1:0] ResultSrc0, ALUSrcB0, ImmSrc0, RegSrc0;
  logic [2:0] ALUControl0;
  logic [3:0] state0;

  int checks;
  int failures;
  logic [3:0] m_nzcv [2];

  always #5 clk = ~clk;

  mc_controlunit #(.ALUCTL_W(3), .EXT_OPS(1'b1)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .Flags(Flags), .mem_ready(mem_ready),
    .PCWrite(PCWrite1), .IRWrite(IRWrite1), .MemWrite(MemWrite1), .RegWrite(RegWrite1),
    .AdrSrc(AdrSrc1), .ALUSrcA(ALUSrcA1), .ResultSrc(ResultSrc1), .ALUSrcB(ALUSrcB1),
    .ImmSrc(ImmSrc1), .RegSrc(RegSrc1), .ALUControl(ALUControl1), .state(state1));

  mc_controlunit #(.ALUCTL_W(3), .EXT_OPS(1'b0)) dut0 (
    .clk(clk), .reset(reset), .Instr(Instr), .Flags(Flags), .mem_ready(mem_ready),
    .PCWrite(PCWrite0), .IRWrite(IRWrite0), .MemWrite(MemWrite0), .RegWrite(RegWrite0),
    .AdrSrc(AdrSrc0), .ALUSrcA(ALUSrcA0), .ResultSrc(ResultSrc0), .ALUSrcB(ALUSrcB0),
    .ImmSrc(ImmSrc0), .RegSrc(RegSrc0), .ALUControl(ALUControl0), .state(state0));

  // One expected clock cycle; -1 in an int field means "not specified for this state".
  typedef struct {
    logic [3:0] st;
    bit         mr;
    bit         exec;
    int         adr, a, b, res, alu0, alu1;
    bit         irw;
    logic [1:0] pcw, mw, rw;   // index 1 = EXT_OPS instance, 0 = plain instance
  } rec_t;

  function automatic rec_t new_rec(input logic [3:0] st);
    rec_t r;
    r.st = st; r.mr = 1'($urandom); r.exec = 1'b0;
    r.adr = -1; r.a = -1; r.b = -1; r.res = -1; r.alu0 = -1; r.alu1 = -1;
    r.irw = 1'b0; r.pcw = 2'b00; r.mw = 2'b00; r.rw = 2'b00;
    return r;
  endfunction

  // Classic ARM formulation: base test from cond[3:1], inverted by cond[0] except for "always".
  function automatic bit cond_model(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c[3:1] != 3'd7 && c[0]) base = !base;
    return base;
  endfunction

  // Mnemonic-level DP semantics: ALU code, register write, flag groups written.
  function automatic void dp_model(input logic [3:0] cmd, input bit s, input bit ext,
                                   output int alu, output bit wr, output bit fnz, output bit fcv);
    alu = 0; wr = 1'b1; fnz = 1'b0; fcv = 1'b0;
    case (cmd)
      4'b0100: begin alu = 0; fnz = s; fcv = s; end                     // ADD
      4'b0010: begin alu = 1; fnz = s; fcv = s; end                     // SUB
      4'b0000: begin alu = 2; fnz = s; end                              // AND
      4'b1100: begin alu = 3; fnz = s; end                              // ORR
      4'b0001: if (ext) begin alu = 4; fnz = s; end                     // EOR
      4'b1010: if (s) begin alu = 1; wr = 1'b0; fnz = 1'b1; fcv = 1'b1; end        // CMP
      4'b1000: if (s && ext) begin alu = 2; wr = 1'b0; fnz = 1'b1; end             // TST
      4'b1011: if (s && ext) begin alu = 0; wr = 1'b0; fnz = 1'b1; fcv = 1'b1; end // CMN
      default: ;
    endcase
  endfunction

  // Expand one instruction into expected cycles, drive it and compare both instances each cycle.
  task automatic run_instr(input string nm, input logic [31:0] ins, input int stalls, input logic [3:0] fl);
    rec_t q[$];
    rec_t r;
    logic [1:0] op, cnd;
    logic rd15;
    int alu [2];
    bit wr [2], fnz [2], fcv [2];
    logic [20:0] o, x, m;
    op = ins[27:26];
    rd15 = (ins[15:12] == 4'hF);
    for (int e = 0; e < 2; e++) begin
      cnd[e] = cond_model(ins[31:28], m_nzcv[e]);
      dp_model(ins[24:21], ins[20], (e == 1), alu[e], wr[e], fnz[e], fcv[e]);
    end
    for (int i = 0; i <= stalls; i++) begin
      r = new_rec(4'd0); r.mr = (i == stalls);
      r.adr = 0; r.a = 1; r.b = 2; r.res = 2; r.alu0 = 0; r.alu1 = 0;
      r.irw = r.mr; r.pcw = {2{r.mr}};
      q.push_back(r);
    end
    r = new_rec(4'd1); r.a = 1; r.b = 2; r.res = 2; q.push_back(r);
    case (op)
      2'b01: begin
        r = new_rec(4'd2); r.a = 0; r.b = 1; r.alu0 = 0; r.alu1 = 0; q.push_back(r);
        if (ins[20]) begin
          for (int i = 0; i <= stalls; i++) begin
            r = new_rec(4'd3); r.mr = (i == stalls); r.adr = 1; q.push_back(r);
          end
          r = new_rec(4'd4); r.res = 1; r.rw = cnd; r.pcw = cnd & {2{rd15}}; q.push_back(r);
        end else begin
          for (int i = 0; i <= stalls; i++) begin
            r = new_rec(4'd5); r.mr = (i == stalls); r.adr = 1; r.mw = cnd; q.push_back(r);
          end
        end
      end
      2'b00: begin
        r = new_rec(ins[25] ? 4'd7 : 4'd6); r.a = 0; r.b = ins[25] ? 1 : 0;
        r.alu0 = alu[0]; r.alu1 = alu[1]; r.exec = 1'b1; q.push_back(r);
        r = new_rec(4'd8); r.res = 0;
        r.rw = {cnd[1] & wr[1], cnd[0] & wr[0]}; r.pcw = r.rw & {2{rd15}}; q.push_back(r);
        for (int e = 0; e < 2; e++) begin
          if (cnd[e]) begin
            if (fnz[e]) m_nzcv[e][3:2] = fl[3:2];
            if (fcv[e]) m_nzcv[e][1:0] = fl[1:0];
          end
        end
      end
      2'b10: begin
        r = new_rec(4'd9); r.a = 0; r.b = 1; r.alu0 = 0; r.alu1 = 0; r.res = 2; r.pcw = cnd;
        q.push_back(r);
      end
      default: ;
    endcase
    for (int k = 0; k < q.size(); k++) begin
      r = q[k];
      @(negedge clk);
      Instr = ins; mem_ready = r.mr; Flags = r.exec ? fl : 4'($urandom);
      #1;
      for (int d = 0; d < 2; d++) begin
        o = (d == 1) ? {state1, PCWrite1, IRWrite1, MemWrite1, RegWrite1, AdrSrc1, ALUSrcA1,
                        ALUSrcB1, ResultSrc1, ALUControl1, ImmSrc1, RegSrc1}
                     : {state0, PCWrite0, IRWrite0, MemWrite0, RegWrite0, AdrSrc0, ALUSrcA0,
                        ALUSrcB0, ResultSrc0, ALUControl0, ImmSrc0, RegSrc0};
        x = '0; m = '0;
        x[20:17] = r.st; x[16] = r.pcw[d]; x[15] = r.irw; x[14] = r.mw[d]; x[13] = r.rw[d];
        m[20:13] = '1;
        x[12] = r.adr[0];     m[12] = (r.adr >= 0);
        x[11] = r.a[0];       m[11] = (r.a >= 0);
        x[10:9] = 2'(r.b);    m[10:9] = {2{r.b >= 0}};
        x[8:7] = 2'(r.res);   m[8:7] = {2{r.res >= 0}};
        x[6:4] = 3'((d == 1) ? r.alu1 : r.alu0);
        m[6:4] = {3{((d == 1) ? r.alu1 : r.alu0) >= 0}};
        x[3:2] = op;
        x[1:0] = {(op == 2'b01) && !ins[20], op == 2'b10};
        m[3:0] = '1;
        checks++;
        if ((o & m) !== (x & m)) begin
          failures++;
          $display("FAIL %s ext%0d cycle %0d: observed %h required %h (care %h)", nm, d, k, o, x, m);
        end
      end
      @(posedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b1; Instr = $urandom; Flags = 4'($urandom);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if (state1 !== 4'd0) begin failures++; $display("FAIL reset_state ext1: observed %0d required 0", state1); end
    checks++;
    if (state0 !== 4'd0) begin failures++; $display("FAIL reset_state ext0: observed %0d required 0", state0); end
    checks++;
    if ({PCWrite1, IRWrite1, MemWrite1, RegWrite1} !== 4'b0000) begin
      failures++; $display("FAIL reset_strobes ext1: observed %b required 0000", {PCWrite1, IRWrite1, MemWrite1, RegWrite1});
    end
    checks++;
    if ({PCWrite0, IRWrite0, MemWrite0, RegWrite0} !== 4'b0000) begin
      failures++; $display("FAIL reset_strobes ext0: observed %b required 0000", {PCWrite0, IRWrite0, MemWrite0, RegWrite0});
    end
    reset = 1'b0; mem_ready = 1'b0;
    m_nzcv[0] = 4'b0000; m_nzcv[1] = 4'b0000;
  endtask

  task automatic test_add();
    run_instr("add_r1_r2_r3", 32'hE0821003, 0, 4'($urandom));
  endtask

  task automatic test_ldr_stall();
    run_instr("ldr_stall", 32'hE5921000, 2, 4'($urandom));
    run_instr("str_stall", 32'hE5821000, 2, 4'($urandom));
  endtask

  task automatic test_flags_branch();
    run_instr("subs_z", 32'hE2511001, 1, 4'b0100);
    run_instr("beq_taken", 32'h0A000000, 0, 4'($urandom));
    run_instr("bne_not", 32'h1A000000, 0, 4'($urandom));
  endtask

  task automatic test_cmp_tst();
    run_instr("cmp_n", 32'hE3500000, 0, 4'b1000);
    run_instr("bmi_taken", 32'h4A000000, 0, 4'($urandom));
    run_instr("tst_z", 32'hE1100001, 0, 4'b0100);
    run_instr("beq_after_tst", 32'h0A000000, 0, 4'($urandom));
    run_instr("bmi_after_tst", 32'h4A000000, 0, 4'($urandom));
  endtask

  task automatic test_add_pc();
    run_instr("add_pc", 32'hE081F002, 0, 4'($urandom));
  endtask

  // Set all flags, start a memory op, stall it, then reset mid-stall with mem_ready high.
  task automatic test_reset_midway(input string nm, input logic [31:0] ins,
                                   input logic [3:0] exp_st, input logic exp_mw);
    run_instr("subs_all", 32'hE2511001, 0, 4'hF);
    @(negedge clk); Instr = ins; mem_ready = 1'b1;
    @(posedge clk);
    repeat (3) begin @(negedge clk); mem_ready = 1'b0; @(posedge clk); end
    @(negedge clk); #1;
    checks++;
    if (state1 !== exp_st) begin failures++; $display("FAIL %s stall_state: observed %0d required %0d", nm, state1, exp_st); end
    checks++;
    if (MemWrite1 !== exp_mw) begin failures++; $display("FAIL %s stall_memwrite: observed %b required %b", nm, MemWrite1, exp_mw); end
    reset = 1'b1; mem_ready = 1'b1; #1;
    checks++;
    if ({PCWrite1, IRWrite1, MemWrite1, RegWrite1} !== 4'b0000) begin
      failures++; $display("FAIL %s reset_strobes ext1: observed %b required 0000", nm, {PCWrite1, IRWrite1, MemWrite1, RegWrite1});
    end
    checks++;
    if ({PCWrite0, IRWrite0, MemWrite0, RegWrite0} !== 4'b0000) begin
      failures++; $display("FAIL %s reset_strobes ext0: observed %b required 0000", nm, {PCWrite0, IRWrite0, MemWrite0, RegWrite0});
    end
    @(posedge clk);
    @(negedge clk); reset = 1'b0; mem_ready = 1'b0; #1;
    checks++;
    if (state1 !== 4'd0) begin failures++; $display("FAIL %s post_reset_state ext1: observed %0d required 0", nm, state1); end
    checks++;
    if (state0 !== 4'd0) begin failures++; $display("FAIL %s post_reset_state ext0: observed %0d required 0", nm, state0); end
    m_nzcv[0] = 4'b0000; m_nzcv[1] = 4'b0000;
    run_instr("beq_cleared", 32'h0A000000, 0, 4'($urandom));
    run_instr("bcs_cleared", 32'h2A000000, 0, 4'($urandom));
    run_instr("bmi_cleared", 32'h4A000000, 0, 4'($urandom));
    run_instr("bvs_cleared", 32'h6A000000, 0, 4'($urandom));
  endtask

  task automatic test_random();
    logic [31:0] ins;
    logic [3:0] cmds [8];
    cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b0001, 4'b1010, 4'b1000, 4'b1011};
    for (int n = 0; n < 250; n++) begin
      ins = $urandom;
      ins[27:26] = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) ins[31:28] = 4'hE;
      if ($urandom_range(0, 3) == 0) ins[15:12] = 4'hF;
      if ($urandom_range(0, 3) != 0) ins[24:21] = cmds[$urandom_range(0, 7)];
      run_instr("random", ins, $urandom_range(0, 2), 4'($urandom));
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; mem_ready = 1'b0; Instr = '0; Flags = '0;
    m_nzcv[0] = 4'b0000; m_nzcv[1] = 4'b0000;
    test_reset();
    test_add();
    test_ldr_stall();
    test_flags_branch();
    test_cmp_tst();
    test_add_pc();
    test_reset_midway("rst_memwr", 32'hE5821000, 4'd5, 1'b1);
    test_reset_midway("rst_memrd", 32'hE5921000, 4'd3, 1'b0);
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
